nios_adc_led_sequencer: RTL and testbench
=========================================

// Module: nios_ADC_led_sequencer
// PURPOSE
//  Controller that owns the slave port of the 10-bit LEDR PIO. Sits between the Nios data master and the PIO.
//  CPU-facing Avalon-MM slave: direct LED value, control, step period, 4-entry pattern table.
//  Sequencer either forwards direct writes (disabled) or steps patterns on a programmable period (enabled).
//  Every PIO access is a registered one-cycle write to PIO address 0.
// PARAMETERS
//  LED_W      10  LED/PIO data width
//  PERIOD_W   24  step-period counter width (clock cycles per step)
//  PAT_DEPTH  4   pattern slots, 1..4, mapped at CPU addresses 4..7
// PORTS
//  clk            in   1         system clock
//  reset_n        in   1         asynchronous reset, active low
//  address        in   3         CPU register select
//  chipselect     in   1         CPU slave select
//  write_n        in   1         CPU write strobe, active low
//  writedata      in   32        CPU write data
//  readdata       out  32        CPU read data, combinational from address, zero-extended
//  pio_address    out  2         to PIO; constant 0
//  pio_chipselect out  1         to PIO; one-cycle pulse per LED update
//  pio_write_n    out  1         to PIO; low together with pio_chipselect
//  pio_writedata  out  32        to PIO; {22'b0, LED value}
// BEHAVIOUR
//  Reg map: 0 DIRECT[LED_W-1:0]; 1 CTRL {b2 oneshot, b1 mode, b0 en}; 2 PERIOD[PERIOD_W-1:0];
//   3 STATUS read {b8 done, b7:4 idx, b0 busy}, any write clears done; 4+i PAT[i], i<PAT_DEPTH; else reads 0.
//  CPU writes take effect on the cycle after chipselect & ~write_n; no wait states.
//  Reset: all regs 0; FSM IDLE; pio_chipselect 0, pio_write_n 1, pio_address 0, pio_writedata 0; done 0.
//  FSM IDLE: DIRECT write -> ISSUE with DIRECT value (PIO sees write 1 cycle after CPU write).
//   en 0->1 -> load cnt=PERIOD, idx=0, LED=PAT[0] -> ISSUE then RUN.
//  RUN: cnt decrements each cycle; at cnt==1 (or PERIOD==0, treated as 1) step -> ISSUE; reload cnt.
//   mode 0: rotate LED left by 1, wrap bit LED_W-1 into bit 0. mode 1: idx=(idx+1)%PAT_DEPTH, LED=PAT[idx].
//  ISSUE: one cycle, pio_chipselect=1, pio_write_n=0; returns to RUN (en=1) or IDLE (en=0).
//  oneshot & mode 1: after issuing PAT[PAT_DEPTH-1] clear en, set done, go IDLE, LED holds last pattern.
//  DIRECT write while en=1: stored only, not forwarded. en 1->0 by CPU: ISSUE with stored DIRECT (restore).
//  Simultaneous step and CPU en clear: CPU wins; restore write issued, step discarded.
//  PERIOD/PAT writes during RUN: used at next reload/step; no restart.
//  busy = (state != IDLE). Async reset mid-ISSUE aborts the write; pio strobes drop immediately.
// CONFIGURATION
//  LEDR_SEQ_IRQ_EN defined: adds output irq (1 bit, reset 0); irq = done & CTRL b3 (irq mask), level.
//   Cleared by any STATUS write.
//  Undefined: no irq port; CTRL b3 reads 0, writes ignored; done still readable in STATUS.
// STRUCTURE
//  Package nios_ADC_led_pkg: reg address localparams (ADDR_DIRECT..ADDR_PAT0), CTRL bit indices,
//   FSM state enum {IDLE, RUN, ISSUE}.
//  Sub-module nios_ADC_led_step_timer: PERIOD_W down-counter with load/enable, step pulse output.
//  Top holds register file, pattern table, FSM, LED shift/index logic, PIO output registers.
// TESTING
//  Reset, then DIRECT=0x155 with en=0 -> exactly one PIO write of 0x155 on the next cycle; readdata(0)=0x155.
//  PAT[0..3]={1,2,4,8}, PERIOD=3, CTRL=0x3 -> PIO writes 1,2,4,8,1 at 3-cycle spacing, one strobe each.
//  CTRL=0x1, PAT[0]=0x200, PERIOD=0 -> PIO sees 0x200 then 0x001 (wrap), a step every cycle.
//  CTRL=0x7 oneshot -> four writes then en=0, STATUS=0x100|idx 3<<4; STATUS write -> done=0.
//  DIRECT=0x0AA during RUN -> no PIO write; CTRL=0 -> single write 0x0AA, busy drops after ISSUE.
//  LEDR_SEQ_IRQ_EN with mask set: irq rises with done, falls after STATUS write; reset_n low mid-RUN clears all.

Source files
------------

// File: rtl/nios_adc_led_sequencer_pkg.sv
// Register map, CTRL bit positions and FSM state type shared by the LEDR PIO sequencer.
// The irq mask bit is only implemented when LEDR_SEQ_IRQ_EN is defined.
package nios_adc_led_sequencer_pkg;

    localparam logic [2:0] ADDR_DIRECT = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_PAT0   = 3'd4;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE     = 1;
    localparam int CTRL_ONESHOT  = 2;
    localparam int CTRL_IRQ_MASK = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ISSUE
    } seqState_t;

endpackage

// File: rtl/nios_adc_led_sequencer_step_timer.sv
// Step-period down-counter: reloads from i_period (a period of 0 behaves as 1) and
// raises o_step during the last cycle of each period.
module nios_adc_led_sequencer_step_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_load,
    input  logic                i_enable,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_step
);

    logic [PERIOD_W-1:0] r_count;
    logic [PERIOD_W-1:0] w_reload;

    assign w_reload = (i_period == '0) ? PERIOD_W'(1) : i_period;
    assign o_step   = i_enable && (r_count == PERIOD_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= w_reload;
        end else if (i_enable) begin
            if (r_count <= PERIOD_W'(1)) begin
                r_count <= w_reload;
            end else begin
                r_count <= r_count - PERIOD_W'(1);
            end
        end
    end

endmodule

// File: rtl/nios_adc_led_sequencer.sv
// LEDR PIO owner: CPU register file, pattern table and step FSM driving one-cycle PIO writes.
// Optional feature: define LEDR_SEQ_IRQ_EN to add the level irq output and CTRL irq mask bit.
module nios_adc_led_sequencer
    import nios_adc_led_sequencer_pkg::*;
#(
    parameter int LED_W     = 10,
    parameter int PERIOD_W  = 24,
    parameter int PAT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata
`ifdef LEDR_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [1:0] IDX_LAST  = 2'(PAT_DEPTH - 1);
    localparam logic [2:0] PAT_LIMIT = 3'(PAT_DEPTH);

    seqState_t           r_state;
    logic [LED_W-1:0]    r_direct;
    logic                r_en;
    logic                r_mode;
    logic                r_oneshot;
`ifdef LEDR_SEQ_IRQ_EN
    logic                r_irqMask;
`endif
    logic [PERIOD_W-1:0] r_period;
    logic [LED_W-1:0]    r_pat [PAT_DEPTH];
    logic                r_done;
    logic [1:0]          r_idx;
    logic [LED_W-1:0]    r_led;
    logic                r_pioCs;
    logic [LED_W-1:0]    r_pioData;

    logic                w_wr;
    logic                w_ctrlWr;
    logic                w_directWr;
    logic                w_enRise;
    logic                w_enFall;
    logic                w_timerEn;
    logic                w_step;
    logic                w_oneshotEnd;
    logic                w_stepNow;
    logic [1:0]          w_patSel;
    logic                w_patValid;
    logic                w_issue;
    logic [LED_W-1:0]    w_nextLed;
    logic [1:0]          w_nextIdx;
    logic                w_unusedWrData;

    assign w_wr           = chipselect && !write_n;
    assign w_ctrlWr       = w_wr && (address == ADDR_CTRL);
    assign w_directWr     = w_wr && (address == ADDR_DIRECT);
    assign w_enRise       = w_ctrlWr && writedata[CTRL_EN] && !r_en;
    assign w_enFall       = w_ctrlWr && !writedata[CTRL_EN] && r_en;
    assign w_patSel       = 2'(address - ADDR_PAT0);
    assign w_patValid     = address[2] && ({1'b0, w_patSel} < PAT_LIMIT);
    assign w_timerEn      = r_en && (r_state != IDLE);
    assign w_unusedWrData = ^writedata[31:PERIOD_W];

    // A CPU enable clear always beats a step or the oneshot end landing on the same edge.
    assign w_oneshotEnd = (r_state == ISSUE) && r_en && r_mode && r_oneshot &&
                          (r_idx == IDX_LAST) && !w_enFall;
    assign w_stepNow    = w_step && !w_enFall && !w_oneshotEnd;

    nios_adc_led_sequencer_step_timer #(
        .PERIOD_W(PERIOD_W)
    ) u_stepTimer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   (w_enRise),
        .i_enable (w_timerEn),
        .i_period (r_period),
        .o_step   (w_step)
    );

    always_comb begin
        w_issue   = 1'b1;
        w_nextLed = r_led;
        w_nextIdx = r_idx;
        if (w_enRise) begin
            w_nextIdx = '0;
            w_nextLed = r_pat[0];
        end else if (w_enFall) begin
            w_nextLed = r_direct;
        end else if (w_directWr && !r_en) begin
            w_nextLed = writedata[LED_W-1:0];
        end else if (w_stepNow) begin
            if (r_mode) begin
                w_nextIdx = (r_idx == IDX_LAST) ? 2'd0 : r_idx + 2'd1;
                w_nextLed = r_pat[w_nextIdx];
            end else begin
                w_nextLed = {r_led[LED_W-2:0], r_led[LED_W-1]};
            end
        end else begin
            w_issue = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_direct  <= '0;
            r_en      <= 1'b0;
            r_mode    <= 1'b0;
            r_oneshot <= 1'b0;
`ifdef LEDR_SEQ_IRQ_EN
            r_irqMask <= 1'b0;
`endif
            r_period  <= '0;
            for (int i = 0; i < PAT_DEPTH; i++) begin
                r_pat[i] <= '0;
            end
            r_done    <= 1'b0;
            r_idx     <= '0;
            r_led     <= '0;
            r_pioCs   <= 1'b0;
            r_pioData <= '0;
        end else begin
            if (w_wr) begin
                case (address)
                    ADDR_DIRECT: r_direct <= writedata[LED_W-1:0];
                    ADDR_CTRL: begin
                        r_en      <= writedata[CTRL_EN];
                        r_mode    <= writedata[CTRL_MODE];
                        r_oneshot <= writedata[CTRL_ONESHOT];
`ifdef LEDR_SEQ_IRQ_EN
                        r_irqMask <= writedata[CTRL_IRQ_MASK];
`endif
                    end
                    ADDR_PERIOD: r_period <= writedata[PERIOD_W-1:0];
                    ADDR_STATUS: r_done <= 1'b0;
                    default: begin
                        if (w_patValid) begin
                            r_pat[w_patSel] <= writedata[LED_W-1:0];
                        end
                    end
                endcase
            end

            // The sequencing actions are placed after the register writes so they win.
            r_pioCs <= w_issue;
            if (w_issue) begin
                r_state   <= ISSUE;
                r_led     <= w_nextLed;
                r_idx     <= w_nextIdx;
                r_pioData <= w_nextLed;
            end else if (w_oneshotEnd) begin
                r_en    <= 1'b0;
                r_done  <= 1'b1;
                r_state <= IDLE;
            end else if (r_state == ISSUE) begin
                r_state <= r_en ? RUN : IDLE;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DIRECT: readdata[LED_W-1:0] = r_direct;
            ADDR_CTRL: begin
                readdata[CTRL_EN]      = r_en;
                readdata[CTRL_MODE]    = r_mode;
                readdata[CTRL_ONESHOT] = r_oneshot;
`ifdef LEDR_SEQ_IRQ_EN
                readdata[CTRL_IRQ_MASK] = r_irqMask;
`endif
            end
            ADDR_PERIOD: readdata[PERIOD_W-1:0] = r_period;
            ADDR_STATUS: begin
                readdata[8]   = r_done;
                readdata[5:4] = r_idx;
                readdata[0]   = (r_state != IDLE);
            end
            default: begin
                if (w_patValid) begin
                    readdata[LED_W-1:0] = r_pat[w_patSel];
                end
            end
        endcase
    end

    assign pio_address    = 2'b00;
    assign pio_chipselect = r_pioCs;
    assign pio_write_n    = !r_pioCs;
    assign pio_writedata  = {{(32 - LED_W){1'b0}}, r_pioData};

`ifdef LEDR_SEQ_IRQ_EN
    assign irq = r_done && r_irqMask;
`endif

endmodule

// File: tb/tb_nios_adc_led_sequencer.sv
// Scoreboard bench for nios_adc_led_sequencer: expected PIO writes (cycle, value) are queued
// from a step-timing model and popped by an independent monitor. Define LEDR_SEQ_IRQ_EN for irq checks.
`timescale 1ns/1ps
module tb_nios_adc_led_sequencer;
    import nios_adc_led_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
`ifdef LEDR_SEQ_IRQ_EN
    logic        irq;
`endif

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          expCycQ[$];
    logic [9:0]  expDatQ[$];
    logic [9:0]  curDirect = 10'd0;

    nios_adc_led_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata)
`ifdef LEDR_SEQ_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    always #5 clk = ~clk;

    // Edge counter: a PIO write decided at edge N is observed at the following negedge with cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every PIO strobe must match the oldest expected write in value and cycle.
    always @(negedge clk) begin
        int         eCyc;
        logic [9:0] eDat;
        if (reset_n && (pio_chipselect || !pio_write_n)) begin
            total++;
            if (expCycQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected pio write: got data=0x%0h at cycle %0d, required none", pio_writedata, cyc);
            end else begin
                eCyc = expCycQ.pop_front();
                eDat = expDatQ.pop_front();
                if (eCyc != cyc || pio_writedata !== {22'b0, eDat} || pio_chipselect !== 1'b1 ||
                    pio_write_n !== 1'b0 || pio_address !== 2'b00) begin
                    bad++;
                    $display("[TB] FAIL pio write: got data=0x%0h cyc=%0d cs=%b wn=%b addr=%0d, required data=0x%0h cyc=%0d cs=1 wn=0 addr=0",
                             pio_writedata, cyc, pio_chipselect, pio_write_n, pio_address, eDat, eCyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One CPU write; it is captured at the next rising edge (cyc + 1).
    task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
    endtask

    task automatic readReg(input logic [2:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
        address = 3'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic pushWrite(input int c, input logic [9:0] d);
        expCycQ.push_back(c);
        expDatQ.push_back(d);
    endtask

    // Reference LED value for the k-th write of a run: rotation of PAT[0] or PAT[k mod 4].
    function automatic logic [9:0] modelLed(input logic [9:0] pat [4], input int k, input bit mode);
        int x;
        int r;
        if (mode) return pat[k % 4];
        x = int'(pat[0]);
        r = k % 10;
        return 10'(((x << r) | (x >> (10 - r))) & 32'h3FF);
    endfunction

    // Run the sequencer for len cycles then clear en; writes land every max(period,1) cycles before the clear.
    task automatic runSeq(input logic [9:0] pat [4], input int period, input bit mode,
                          input int len, input bit midDirect, input logic [9:0] newDirect);
        int          e;
        int          f;
        int          p;
        int          nWrites;
        logic [31:0] status;
        for (int i = 0; i < 4; i++) applyStimulus(3'(4 + i), {22'b0, pat[i]});
        applyStimulus(ADDR_PERIOD, 32'(period));
        p = (period == 0) ? 1 : period;
        e = cyc + 1;
        f = e + len;
        nWrites = 0;
        for (int t = e; t < f; t += p) begin
            pushWrite(t, modelLed(pat, nWrites, mode));
            nWrites++;
        end
        if (midDirect && len >= 2) curDirect = newDirect;
        pushWrite(f, curDirect);
        applyStimulus(ADDR_CTRL, mode ? 32'h3 : 32'h1);
        for (int i = 1; i < len; i++) begin
            if (midDirect && i == 1) begin
                applyStimulus(ADDR_DIRECT, {22'b0, newDirect});
            end else if (i == 2) begin
                readReg(ADDR_STATUS, status);
                checkOutput("busy while running", {31'b0, status[0]}, 32'h1);
            end else begin
                tick(1);
            end
        end
        applyStimulus(ADDR_CTRL, 32'h0);
        tick(2);
        readReg(ADDR_STATUS, status);
        checkOutput("status after restore", status, mode ? (32'((nWrites - 1) % 4) << 4) : 32'h0);
    endtask

    initial begin
        logic [31:0] v;
        logic [9:0]  pat [4];
        logic [31:0] ctrlVal;
        int          e;

        // Reset phase: outputs and registers must all be cleared.
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset pio_chipselect", {31'b0, pio_chipselect}, 32'h0);
        checkOutput("reset pio_write_n", {31'b0, pio_write_n}, 32'h1);
        checkOutput("reset pio_writedata", pio_writedata, 32'h0);
        checkOutput("reset pio_address", {30'b0, pio_address}, 32'h0);
`ifdef LEDR_SEQ_IRQ_EN
        checkOutput("reset irq", {31'b0, irq}, 32'h0);
`endif
        for (int a = 0; a < 8; a++) begin
            readReg(3'(a), v);
            checkOutput("reset register read", v, 32'h0);
        end
        reset_n = 1'b1;
        tick(2);

        // Direct write while disabled is forwarded on the next cycle.
        pushWrite(cyc + 1, 10'h155);
        applyStimulus(ADDR_DIRECT, 32'h155);
        curDirect = 10'h155;
        readReg(ADDR_DIRECT, v);
        checkOutput("direct readback", v, 32'h155);
        tick(2);

        pat = '{10'h001, 10'h002, 10'h004, 10'h008};
        runSeq(pat, 3, 1'b1, 14, 1'b0, 10'h0);

        pat = '{10'h200, 10'h0F0, 10'h00F, 10'h3C3};
        runSeq(pat, 0, 1'b0, 4, 1'b0, 10'h0);

        // Direct write during a run is only stored, then restored when en clears.
        pat = '{10'h081, 10'h102, 10'h204, 10'h3FF};
        runSeq(pat, 2, 1'b0, 7, 1'b1, 10'h0AA);

        // Step falling on the same edge as the en clear is dropped.
        pat = '{10'h111, 10'h222, 10'h333, 10'h044};
        runSeq(pat, 3, 1'b1, 6, 1'b0, 10'h0);

        // Oneshot pattern run ends by itself with done set and LED left on the last pattern.
        pat = '{10'h011, 10'h022, 10'h044, 10'h088};
        for (int i = 0; i < 4; i++) applyStimulus(3'(4 + i), {22'b0, pat[i]});
        applyStimulus(ADDR_PERIOD, 32'd2);
`ifdef LEDR_SEQ_IRQ_EN
        ctrlVal = 32'hF;
`else
        ctrlVal = 32'h7;
`endif
        e = cyc + 1;
        for (int k = 0; k < 4; k++) pushWrite(e + 2 * k, pat[k]);
        applyStimulus(ADDR_CTRL, ctrlVal);
        tick(12);
        readReg(ADDR_CTRL, v);
        checkOutput("ctrl after oneshot", v, ctrlVal & 32'hFFFF_FFFE);
        readReg(ADDR_STATUS, v);
        checkOutput("status after oneshot", v, 32'h130);
`ifdef LEDR_SEQ_IRQ_EN
        checkOutput("irq raised with done", {31'b0, irq}, 32'h1);
`endif
        applyStimulus(ADDR_STATUS, 32'h0);
        readReg(ADDR_STATUS, v);
        checkOutput("status after clear", v, 32'h030);
`ifdef LEDR_SEQ_IRQ_EN
        checkOutput("irq after status write", {31'b0, irq}, 32'h0);
`endif
        applyStimulus(ADDR_CTRL, 32'h0);
        tick(3);

        // Randomised runs against the timing model.
        for (int n = 0; n < 10; n++) begin
            int   per;
            int   len;
            bit   mode;
            bit   mid;
            for (int i = 0; i < 4; i++) pat[i] = 10'($urandom);
            per  = int'($urandom_range(0, 4));
            len  = int'($urandom_range(1, 16));
            mode = 1'($urandom_range(0, 1));
            mid  = (len >= 3) && ($urandom_range(0, 1) == 1);
            runSeq(pat, per, mode, len, mid, 10'($urandom));
        end

        // Asynchronous reset during the ISSUE cycle drops the strobes at once.
        applyStimulus(ADDR_PERIOD, 32'd5);
        applyStimulus(ADDR_CTRL, 32'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("reset mid-issue chipselect", {31'b0, pio_chipselect}, 32'h0);
        checkOutput("reset mid-issue write_n", {31'b0, pio_write_n}, 32'h1);
        readReg(ADDR_CTRL, v);
        checkOutput("reset mid-issue ctrl", v, 32'h0);
        readReg(ADDR_PERIOD, v);
        checkOutput("reset mid-issue period", v, 32'h0);
        readReg(ADDR_STATUS, v);
        checkOutput("reset mid-issue status", v, 32'h0);
        reset_n = 1'b1;
        tick(8);

        checkOutput("expected writes left over", 32'(expCycQ.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
